// File: rtl/life_grid_engine_if.sv
// Bundle for the life grid engine: start/busy/done handshake, 1-bit source-plane
// read port, 1-bit destination-plane write port and the generation counter.
interface life_grid_engine_if #(
  parameter int AW    = 12,
  parameter int GEN_W = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             rd_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             wr_data;
  logic [GEN_W-1:0] gen_count;

  modport master (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, gen_count
  );

  modport slave (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, gen_count
  );
endinterface

// File: rtl/life_grid_engine.sv
// Sequential B3/S23 next-generation engine: walks a ROWS x COLS plane in raster
// order, fetching each cell's 3x3 neighbourhood over a 1-bit read port.
module life_grid_engine #(
  parameter int COLS  = 64,
  parameter int ROWS  = 48,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  life_grid_engine_if.slave bus
);
  localparam int X_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int Y_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW  = Y_W + X_W;
  localparam logic [X_W-1:0] X_MAX = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic           vld;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } slot_t;

  // Slot k (UL,U,UR,L,SELF,R,DL,D,DR) around (x,y); edges use explicit compares so
  // non-power-of-two sizes never produce out-of-range coordinates.
  function automatic slot_t slot_of(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                    input logic [3:0] k);
    slot_t s;
    logic  off_x;
    logic  off_y;
    off_x = 1'b0;
    off_y = 1'b0;
    s.x   = x;
    s.y   = y;
    case (k)
      4'd0, 4'd3, 4'd6: begin
        off_x = (x == '0);
        s.x   = off_x ? X_MAX : x - X_W'(1);
      end
      4'd2, 4'd5, 4'd8: begin
        off_x = (x == X_MAX);
        s.x   = off_x ? '0 : x + X_W'(1);
      end
      default: ;
    endcase
    case (k)
      4'd0, 4'd1, 4'd2: begin
        off_y = (y == '0);
        s.y   = off_y ? Y_MAX : y - Y_W'(1);
      end
      4'd6, 4'd7, 4'd8: begin
        off_y = (y == Y_MAX);
        s.y   = off_y ? '0 : y + Y_W'(1);
      end
      default: ;
    endcase
    s.vld = (WRAP != 0) || !(off_x || off_y);
    return s;
  endfunction

  state_t           r_state;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [3:0]       r_k;
  logic [3:0]       r_count;
  logic             r_self;
  logic             r_pend;
  logic [3:0]       r_pend_k;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;
  logic [AW-1:0]    r_rd_addr;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic             r_wr_data;
  logic [GEN_W-1:0] r_gen_count;

  logic             w_last_x;
  logic             w_last;
  logic [X_W-1:0]   w_nx;
  logic [Y_W-1:0]   w_ny;
  slot_t            w_step;
  slot_t            w_adv;
  slot_t            w_home;
  logic [3:0]       w_count_acc;
  logic             w_self_acc;
  logic             w_next_state;

  always_comb begin
    w_last_x = (r_x == X_MAX);
    w_last   = w_last_x && (r_y == Y_MAX);
    w_nx     = w_last_x ? '0 : r_x + X_W'(1);
    w_ny     = w_last_x ? r_y + Y_W'(1) : r_y;
    w_step   = slot_of(r_x, r_y, r_k + 4'd1);
    w_adv    = slot_of(w_nx, w_ny, 4'd0);
    w_home   = slot_of('0, '0, 4'd0);
  end

  // r_pend marks the cycle in which the datum for slot r_pend_k is on rd_data.
  always_comb begin
    w_count_acc = r_count;
    w_self_acc  = r_self;
    if (r_pend) begin
      if (r_pend_k == 4'd4) w_self_acc  = bus.rd_data;
      else                  w_count_acc = r_count + {3'b000, bus.rd_data};
    end
    w_next_state = (w_count_acc == 4'd3) || (w_self_acc && (w_count_acc == 4'd2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_k         <= '0;
      r_count     <= '0;
      r_self      <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_k    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 1'b0;
      r_gen_count <= '0;
    end else begin
      r_pend   <= r_rd_en;
      r_pend_k <= r_k;
      r_count  <= w_count_acc;
      r_self   <= w_self_acc;
      r_done   <= 1'b0;
      r_wr_en  <= 1'b0;
      case (r_state)
        // DONE doubles as an accept point so a held start relaunches without an idle gap.
        S_IDLE, S_DONE: begin
          if (r_state == S_DONE) r_gen_count <= r_gen_count + GEN_W'(1);
          if (bus.start) begin
            r_state   <= S_FETCH;
            r_busy    <= 1'b1;
            r_x       <= '0;
            r_y       <= '0;
            r_k       <= '0;
            r_count   <= '0;
            r_self    <= 1'b0;
            r_rd_en   <= w_home.vld;
            r_rd_addr <= {w_home.y, w_home.x};
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (r_k == 4'd8) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
          end else begin
            r_k       <= r_k + 4'd1;
            r_rd_en   <= w_step.vld;
            r_rd_addr <= {w_step.y, w_step.x};
          end
        end
        S_DRAIN: begin
          r_state   <= S_WRITE;
          r_wr_en   <= 1'b1;
          r_wr_addr <= {r_y, r_x};
          r_wr_data <= w_next_state;
        end
        S_WRITE: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= S_FETCH;
            r_x       <= w_nx;
            r_y       <= w_ny;
            r_k       <= '0;
            r_count   <= '0;
            r_self    <= 1'b0;
            r_rd_en   <= w_adv.vld;
            r_rd_addr <= {w_adv.y, w_adv.x};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.gen_count = r_gen_count;
endmodule

// File: tb/tb_life_grid_engine.sv
// Directed checks of life_grid_engine over several grid shapes and boundary modes.
`timescale 1ns/1ps
module tb_life_grid_engine;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // A: 5x5 dead border, B: 4x4 torus, C: 4x4 dead border, D: 5x3 torus, E: 5x5 torus
  life_grid_engine_if #(.AW(6), .GEN_W(16)) if_a ();
  life_grid_engine_if #(.AW(4), .GEN_W(16)) if_b ();
  life_grid_engine_if #(.AW(4), .GEN_W(16)) if_c ();
  life_grid_engine_if #(.AW(5), .GEN_W(16)) if_d ();
  life_grid_engine_if #(.AW(6), .GEN_W(16)) if_e ();

  life_grid_engine #(.COLS(5), .ROWS(5), .WRAP(0), .GEN_W(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  life_grid_engine #(.COLS(4), .ROWS(4), .WRAP(1), .GEN_W(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  life_grid_engine #(.COLS(4), .ROWS(4), .WRAP(0), .GEN_W(16)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  life_grid_engine #(.COLS(5), .ROWS(3), .WRAP(1), .GEN_W(16)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));
  life_grid_engine #(.COLS(5), .ROWS(5), .WRAP(1), .GEN_W(16)) u_e (.clk(clk), .rst_n(rst_n), .bus(if_e));

  logic [63:0] src_a, dst_a, src_e, dst_e;
  logic [15:0] src_b, dst_b, src_c, dst_c;
  logic [31:0] src_d, dst_d;

  // Idle read slots return 1 so a counted non-read shows up as a wrong cell.
  always @(posedge clk) begin
    if_a.rd_data <= if_a.rd_en ? src_a[if_a.rd_addr] : 1'b1;
    if_b.rd_data <= if_b.rd_en ? src_b[if_b.rd_addr] : 1'b1;
    if_c.rd_data <= if_c.rd_en ? src_c[if_c.rd_addr] : 1'b1;
    if_d.rd_data <= if_d.rd_en ? src_d[if_d.rd_addr] : 1'b1;
    if_e.rd_data <= if_e.rd_en ? src_e[if_e.rd_addr] : 1'b1;
  end

  int wr_n_a, ord_err_a, done_n_a, done_cyc_a;
  int wr_n_b, done_n_b, done_cyc_b;
  int wr_n_c, rd_n_c, rd0_c, done_n_c, done_cyc_c;
  int wr_n_d, rd_n_d, rd_i_d, bad_d, done_n_d, done_cyc_d;
  int wr_n_e, ones_e, done_n_e, done_cyc_e;
  int busy_err, ovl_err;
  logic [4:0] d_rd [0:8];

  task automatic clear_mon();
    wr_n_a = 0; ord_err_a = 0; done_n_a = 0; done_cyc_a = 0;
    wr_n_b = 0; done_n_b = 0; done_cyc_b = 0;
    wr_n_c = 0; rd_n_c = 0; rd0_c = 0; done_n_c = 0; done_cyc_c = 0;
    wr_n_d = 0; rd_n_d = 0; rd_i_d = 0; bad_d = 0; done_n_d = 0; done_cyc_d = 0;
    wr_n_e = 0; ones_e = 0; done_n_e = 0; done_cyc_e = 0;
    busy_err = 0; ovl_err = 0;
    dst_a = '0; dst_b = '0; dst_c = '0; dst_d = '0; dst_e = '0;
    for (int i = 0; i < 9; i++) d_rd[i] = '1;
  endtask

  always @(negedge clk) begin
    if (if_a.wr_en) begin
      dst_a[if_a.wr_addr] = if_a.wr_data;
      if (if_a.wr_addr != 6'(((wr_n_a % 25) / 5) * 8 + (wr_n_a % 25) % 5)) ord_err_a++;
      wr_n_a++;
    end
    if (if_a.done) begin done_n_a++; done_cyc_a = cyc; if (if_a.busy) busy_err++; end
    if (if_b.wr_en) begin dst_b[if_b.wr_addr] = if_b.wr_data; wr_n_b++; end
    if (if_b.done) begin done_n_b++; done_cyc_b = cyc; if (if_b.busy) busy_err++; end
    if (if_c.rd_en) begin rd_n_c++; if (wr_n_c == 0) rd0_c++; end
    if (if_c.wr_en) begin dst_c[if_c.wr_addr] = if_c.wr_data; wr_n_c++; end
    if (if_c.done) begin done_n_c++; done_cyc_c = cyc; end
    if (if_d.rd_en) begin
      rd_n_d++;
      if (if_d.rd_addr[2:0] >= 3'd5 || if_d.rd_addr[4:3] >= 2'd3) bad_d++;
      if (wr_n_d == 4) begin
        if (rd_i_d < 9) d_rd[rd_i_d] = if_d.rd_addr;
        rd_i_d++;
      end
    end
    if (if_d.wr_en) begin dst_d[if_d.wr_addr] = if_d.wr_data; wr_n_d++; end
    if (if_d.done) begin done_n_d++; done_cyc_d = cyc; end
    if (if_e.wr_en) begin dst_e[if_e.wr_addr] = if_e.wr_data; wr_n_e++; if (if_e.wr_data) ones_e++; end
    if (if_e.done) begin done_n_e++; done_cyc_e = cyc; if (if_e.busy) busy_err++; end
    if ((if_a.rd_en && if_a.wr_en) || (if_b.rd_en && if_b.wr_en) || (if_c.rd_en && if_c.wr_en) ||
        (if_d.rd_en && if_d.wr_en) || (if_e.rd_en && if_e.wr_en)) ovl_err++;
  end

  logic [63:0] exp_a, exp_d;
  logic [15:0] exp_b;

  initial begin
    int c0;
    int c1;
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0; if_d.start = 1'b0; if_e.start = 1'b0;
    // Blinker row y=2 in 5x5 (addr = y*8+x); next state is column x=2.
    src_a = '0; src_a[17] = 1'b1; src_a[18] = 1'b1; src_a[19] = 1'b1;
    exp_a = '0; exp_a[10] = 1'b1; exp_a[18] = 1'b1; exp_a[26] = 1'b1;
    // Corners (3,0),(0,3),(3,3) in 4x4 (addr = y*4+x).
    src_b = '0; src_b[3] = 1'b1; src_b[12] = 1'b1; src_b[15] = 1'b1;
    src_c = src_b;
    exp_b = src_b; exp_b[0] = 1'b1;
    // Row y=1 x=1..3 on a 5x3 torus (addr = y*8+x) becomes the full column x=2.
    src_d = '0; src_d[9] = 1'b1; src_d[10] = 1'b1; src_d[11] = 1'b1;
    exp_d = '0; exp_d[2] = 1'b1; exp_d[10] = 1'b1; exp_d[18] = 1'b1;
    src_e = '0;
    for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) src_e[y * 8 + x] = 1'b1;
    clear_mon();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_a", 64'({if_a.busy, if_a.done, if_a.rd_en, if_a.wr_en, if_a.wr_data,
                             if_a.rd_addr, if_a.wr_addr, if_a.gen_count}), 64'd0);
    check_eq("reset_d", 64'({if_d.busy, if_d.done, if_d.rd_en, if_d.wr_en, if_d.wr_data,
                             if_d.rd_addr, if_d.wr_addr, if_d.gen_count}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // One generation on every instance, launched on the same edge.
    if_a.start = 1'b1; if_b.start = 1'b1; if_c.start = 1'b1; if_d.start = 1'b1; if_e.start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0; if_d.start = 1'b0; if_e.start = 1'b0;
    check_eq("busy_first_cycle", 64'(if_a.busy), 64'd1);
    check_eq("c_home_ul_no_read", 64'(if_c.rd_en), 64'd0);
    check_eq("b_home_ul_addr", 64'({if_b.rd_en, if_b.rd_addr}), 64'h1F);
    for (int i = 0; i < 400 && !(done_n_a > 0 && done_n_b > 0 && done_n_c > 0 && done_n_d > 0 && done_n_e > 0); i++) begin
      @(negedge clk); #1;
    end
    check_eq("gen1_all_done", 64'(done_n_a > 0 && done_n_b > 0 && done_n_c > 0 && done_n_d > 0 && done_n_e > 0), 64'd1);
    @(posedge clk); #1;
    check_eq("a_done_cycle", 64'(done_cyc_a - c0), 64'd275);
    check_eq("b_done_cycle", 64'(done_cyc_b - c0), 64'd176);
    check_eq("c_done_cycle", 64'(done_cyc_c - c0), 64'd176);
    check_eq("d_done_cycle", 64'(done_cyc_d - c0), 64'd165);
    check_eq("e_done_cycle", 64'(done_cyc_e - c0), 64'd275);
    check_eq("a_gen_count", 64'(if_a.gen_count), 64'd1);
    check_eq("a_writes", 64'(wr_n_a), 64'd25);
    check_eq("a_raster_order", 64'(ord_err_a), 64'd0);
    check_eq("a_blinker", dst_a, exp_a);
    check_eq("b_corner00_birth", 64'(dst_b[0]), 64'd1);
    check_eq("b_grid", 64'(dst_b), 64'(exp_b));
    check_eq("c_corner00_dead", 64'(dst_c[0]), 64'd0);
    check_eq("c_grid", 64'(dst_c), 64'd0);
    check_eq("c_writes", 64'(wr_n_c), 64'd16);
    check_eq("c_reads_total", 64'(rd_n_c), 64'd100);
    check_eq("c_reads_cell00", 64'(rd0_c), 64'd4);
    check_eq("d_cell40_r_addr", 64'(d_rd[5]), 64'd0);
    check_eq("d_cell40_ul_addr", 64'(d_rd[0]), 64'(5'b10_011));
    check_eq("d_addr_in_range", 64'(bad_d), 64'd0);
    check_eq("d_reads_total", 64'(rd_n_d), 64'd135);
    check_eq("d_grid", 64'(dst_d), exp_d);
    check_eq("e_writes", 64'(wr_n_e), 64'd25);
    check_eq("e_overcrowd_ones", 64'(ones_e), 64'd0);
    check_eq("busy_low_at_done", 64'(busy_err), 64'd0);
    check_eq("rd_wr_overlap", 64'(ovl_err), 64'd0);

    // Start pulses during busy must not disturb A.
    clear_mon();
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    if_a.start = 1'b0;
    repeat (60) @(negedge clk);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    repeat (100) @(negedge clk);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    for (int i = 0; i < 400 && done_n_a == 0; i++) begin @(negedge clk); #1; end
    check_eq("busy_pulse_done_cycle", 64'(done_cyc_a - c0), 64'd275);
    repeat (300) @(negedge clk);
    check_eq("busy_pulse_one_done", 64'(done_n_a), 64'd1);
    check_eq("busy_pulse_gen", 64'(if_a.gen_count), 64'd2);
    check_eq("busy_pulse_writes", 64'(wr_n_a), 64'd25);
    check_eq("busy_pulse_grid", dst_a, exp_a);

    // Start held high across two generations on E.
    src_e = src_a;
    clear_mon();
    @(negedge clk);
    if_e.start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < 400 && done_n_e == 0; i++) begin @(negedge clk); #1; end
    check_eq("held_first_done", 64'(done_cyc_e - c0), 64'd275);
    @(posedge clk); #1;
    c1 = cyc;
    if_e.start = 1'b0;
    check_eq("held_relaunch_period", 64'(c1 - c0), 64'd276);
    check_eq("held_relaunch_busy", 64'(if_e.busy), 64'd1);
    check_eq("held_gen_after_first", 64'(if_e.gen_count), 64'd2);
    for (int i = 0; i < 400 && done_n_e < 2; i++) begin @(negedge clk); #1; end
    check_eq("held_second_done", 64'(done_cyc_e - c1), 64'd275);
    @(posedge clk); #1;
    check_eq("held_gen_after_second", 64'(if_e.gen_count), 64'd3);
    check_eq("held_writes", 64'(wr_n_e), 64'd50);
    check_eq("held_grid", dst_e, exp_a);
    repeat (20) @(negedge clk);
    check_eq("held_stops", 64'({if_e.busy, 8'(done_n_e)}), 64'd2);

    // Reset during cell 7's fetch on B.
    clear_mon();
    @(negedge clk);
    if_b.start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    if_b.start = 1'b0;
    for (int i = 0; i < 200 && cyc < c0 + 80; i++) @(negedge clk);
    check_eq("mid_run_writes_before", 64'(wr_n_b), 64'd7);
    rst_n = 1'b0;
    #1;
    check_eq("mid_run_reset_b", 64'({if_b.busy, if_b.done, if_b.rd_en, if_b.wr_en, if_b.wr_data,
                                     if_b.rd_addr, if_b.wr_addr, if_b.gen_count}), 64'd0);
    check_eq("mid_run_reset_a_gen", 64'(if_a.gen_count), 64'd0);
    repeat (5) @(negedge clk);
    check_eq("mid_run_no_writes", 64'(wr_n_b), 64'd7);
    rst_n = 1'b1;
    @(negedge clk);
    if_b.start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    if_b.start = 1'b0;
    check_eq("restart_first_rd", 64'({if_b.rd_en, if_b.rd_addr}), 64'h1F);
    for (int i = 0; i < 400 && done_n_b == 0; i++) begin @(negedge clk); #1; end
    check_eq("restart_done_cycle", 64'(done_cyc_b - c0), 64'd176);
    @(posedge clk); #1;
    check_eq("restart_gen", 64'(if_b.gen_count), 64'd1);
    check_eq("restart_grid", 64'(dst_b), 64'(exp_b));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
